// File: rtl/es_mapeada.sv
// Memory-mapped I/O unit for the upper half of the data address space:
// output port registers, synchronised input ports with change interrupts, and a down-counting timer.
module es_mapeada #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 7,
    parameter int N_IN    = 4,
    parameter int N_OUT   = 4,
    parameter int TIMER_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         rdata,
    input  logic [N_IN*DATA_W-1:0]    in_ports,
    output logic [N_OUT*DATA_W-1:0]   out_ports,
    output logic                      irq
);

    localparam int HI_W = TIMER_W - DATA_W;

    localparam logic [ADDR_W-1:0] A_PEND   = ADDR_W'('h40);
    localparam logic [ADDR_W-1:0] A_MASK   = ADDR_W'('h41);
    localparam logic [ADDR_W-1:0] A_RLD_LO = ADDR_W'('h48);
    localparam logic [ADDR_W-1:0] A_RLD_HI = ADDR_W'('h49);
    localparam logic [ADDR_W-1:0] A_TCTL   = ADDR_W'('h4A);
    localparam logic [ADDR_W-1:0] A_CNT_LO = ADDR_W'('h4B);
    localparam logic [ADDR_W-1:0] A_CNT_HI = ADDR_W'('h4C);

    logic [DATA_W-1:0]      out_reg [N_OUT];
    logic [N_IN*DATA_W-1:0] sync_p0;
    logic [N_IN*DATA_W-1:0] sync_p1;
    logic [N_IN*DATA_W-1:0] hist_p2;
    logic [N_IN:0]          pend;
    logic [N_IN:0]          mask;
    logic [TIMER_W-1:0]     reload;
    logic [TIMER_W-1:0]     count;
    logic                   t_en;
    logic                   t_auto;

    logic                   wr;
    logic                   fire;
    logic [N_IN:0]          evt;
    logic [N_IN:0]          clr;

    assign wr   = en & we;
    assign fire = t_en && (count == '0);

    always_comb begin
        evt = '0;
        for (int i = 0; i < N_IN; i++) begin
            evt[i] = |(sync_p1[i*DATA_W +: DATA_W] ^ hist_p2[i*DATA_W +: DATA_W]);
        end
        evt[N_IN] = fire;
        clr = (wr && addr == A_PEND) ? wdata[N_IN:0] : '0;
    end

    genvar g;
    generate
        for (g = 0; g < N_OUT; g++) begin : g_out
            assign out_ports[g*DATA_W +: DATA_W] = out_reg[g];
        end
    endgenerate

    assign irq = |(pend & mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_OUT; i++) begin
                out_reg[i] <= '0;
            end
            sync_p0 <= '0;
            sync_p1 <= '0;
            hist_p2 <= '0;
            pend    <= '0;
            mask    <= '0;
            reload  <= '0;
            count   <= '0;
            t_en    <= 1'b0;
            t_auto  <= 1'b0;
        end else begin
            // Two-flop synchroniser followed by the history stage used for change detection
            sync_p0 <= in_ports;
            sync_p1 <= sync_p0;
            hist_p2 <= sync_p1;

            // A hardware event in the same cycle as its clear wins
            pend <= (pend & ~clr) | evt;

            for (int i = 0; i < N_OUT; i++) begin
                if (wr && addr == ADDR_W'(i)) out_reg[i] <= wdata;
            end
            if (wr && addr == A_MASK)   mask <= wdata[N_IN:0];
            if (wr && addr == A_RLD_LO) reload[DATA_W-1:0] <= wdata;
            if (wr && addr == A_RLD_HI) reload[TIMER_W-1:DATA_W] <= wdata[HI_W-1:0];

            // A TCTL write overrides whatever the timer would have done this cycle
            if (wr && addr == A_TCTL) begin
                t_en   <= wdata[0];
                t_auto <= wdata[1];
                if (wdata[0]) count <= reload;
            end else if (t_en) begin
                if (count == '0) begin
                    if (t_auto) count <= reload;
                    else        t_en  <= 1'b0;
                end else begin
                    count <= count - TIMER_W'(1);
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (en) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (addr == ADDR_W'(i)) rdata = out_reg[i];
            end
            for (int i = 0; i < N_IN; i++) begin
                if (addr == ADDR_W'(32 + i)) rdata = sync_p1[i*DATA_W +: DATA_W];
            end
            case (addr)
                A_PEND:   rdata = DATA_W'(pend);
                A_MASK:   rdata = DATA_W'(mask);
                A_RLD_LO: rdata = reload[DATA_W-1:0];
                A_RLD_HI: rdata = DATA_W'(reload[TIMER_W-1:DATA_W]);
                A_TCTL:   rdata = DATA_W'({t_auto, t_en});
                A_CNT_LO: rdata = count[DATA_W-1:0];
                A_CNT_HI: rdata = DATA_W'(count[TIMER_W-1:DATA_W]);
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_es_mapeada.sv
// Directed bench for es_mapeada with default parameters (8-bit data, 4 in, 4 out, 16-bit timer).
module tb_es_mapeada;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        we;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic [31:0] in_ports;
    logic [31:0] out_ports;
    logic        irq;

    int n_pass = 0;
    int n_total = 0;

    es_mapeada dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .in_ports  (in_ports),
        .out_ports (out_ports),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        en = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        en = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [6:0] a, input logic [7:0] exp);
        en = 1'b1; we = 1'b0; addr = a;
        #1;
        chk(tag, {24'h0, rdata}, {24'h0, exp});
        en = 1'b0;
    endtask

    logic [6:0] offs [15] = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h20, 7'h21, 7'h22, 7'h23,
                             7'h40, 7'h41, 7'h48, 7'h49, 7'h4A, 7'h4B, 7'h4C};

    initial begin
        reset = 1'b1; en = 1'b0; we = 1'b0; addr = '0; wdata = '0; in_ports = '0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset state
        for (int i = 0; i < 15; i++) begin
            rd($sformatf("reset_rd_%0h", offs[i]), offs[i], 8'h00);
            tick();
        end
        chk("reset_irq", {31'h0, irq}, 32'h0);
        chk("reset_out", out_ports, 32'h0);

        // Output port write and unmapped offset
        wr(7'h02, 8'hA5);
        chk("out2_ports", out_ports, 32'h00A5_0000);
        rd("out2_rd", 7'h02, 8'hA5);
        wr(7'h10, 8'hFF);
        chk("unmapped_wr_ports", out_ports, 32'h00A5_0000);
        rd("unmapped_rd", 7'h10, 8'h00);
        addr = 7'h02; en = 1'b0; #1;
        chk("rd_en0", {24'h0, rdata}, 32'h0);

        // Input change on port 0 -> latency and interrupt
        wr(7'h41, 8'h01);
        in_ports = 32'h0000_003C;
        tick();
        rd("in0_k", 7'h20, 8'h00);
        tick();
        rd("in0_k1", 7'h20, 8'h3C);
        rd("pend_k1", 7'h40, 8'h00);
        tick();
        rd("pend_k2", 7'h40, 8'h01);
        chk("irq_k2", {31'h0, irq}, 32'h1);
        wr(7'h40, 8'h01);
        rd("pend_clr", 7'h40, 8'h00);
        chk("irq_clr", {31'h0, irq}, 32'h0);

        // Clear collides with a new change event
        in_ports = 32'h0000_003D;
        tick(); tick(); tick();
        rd("pend_coll_pre", 7'h40, 8'h01);
        in_ports = 32'h0000_003E;
        tick(); tick();
        wr(7'h40, 8'h01);
        rd("pend_coll", 7'h40, 8'h01);
        chk("irq_coll", {31'h0, irq}, 32'h1);
        wr(7'h40, 8'h01);
        rd("pend_coll_clr", 7'h40, 8'h00);

        // Auto-reload timer, RELOAD = 3 -> event every 4 cycles
        wr(7'h41, 8'h10);
        wr(7'h48, 8'h03);
        wr(7'h4A, 8'h03);
        rd("cnt_load", 7'h4B, 8'h03);
        rd("tctl_rd", 7'h4A, 8'h03);
        tick(); tick(); tick();
        rd("tmr_t3_pend", 7'h40, 8'h00);
        rd("tmr_t3_cnt", 7'h4B, 8'h00);
        tick();
        rd("tmr_t4_pend", 7'h40, 8'h10);
        chk("tmr_t4_irq", {31'h0, irq}, 32'h1);
        rd("tmr_t4_cnt", 7'h4B, 8'h03);
        wr(7'h40, 8'h10);
        rd("tmr_t5_pend", 7'h40, 8'h00);
        tick(); tick();
        rd("tmr_t7_pend", 7'h40, 8'h00);
        tick();
        rd("tmr_t8_pend", 7'h40, 8'h10);
        wr(7'h4A, 8'h00);
        rd("tmr_stop_cnt", 7'h4B, 8'h03);
        rd("tmr_stop_tctl", 7'h4A, 8'h00);
        wr(7'h40, 8'h10);

        // One-shot
        wr(7'h4A, 8'h01);
        tick(); tick(); tick();
        rd("one_t3_pend", 7'h40, 8'h00);
        tick();
        rd("one_t4_pend", 7'h40, 8'h10);
        rd("one_t4_tctl", 7'h4A, 8'h00);
        wr(7'h40, 8'h10);
        tick(); tick(); tick(); tick(); tick();
        rd("one_after_pend", 7'h40, 8'h00);
        rd("one_after_cnt", 7'h4B, 8'h00);

        // RELOAD high byte
        wr(7'h49, 8'h01);
        rd("rld_hi", 7'h49, 8'h01);
        wr(7'h4A, 8'h01);
        rd("cnt_hi", 7'h4C, 8'h01);
        rd("cnt_lo", 7'h4B, 8'h03);
        wr(7'h4A, 8'h00);
        wr(7'h49, 8'h00);

        // Reset while timer runs with PEND = 0x11
        wr(7'h41, 8'h11);
        wr(7'h4A, 8'h03);
        in_ports = 32'h0000_0040;
        tick(); tick(); tick();
        rd("mid_pend_in", 7'h40, 8'h01);
        tick();
        rd("mid_pend_11", 7'h40, 8'h11);
        chk("mid_irq", {31'h0, irq}, 32'h1);
        reset = 1'b1;
        tick();
        rd("rst_cnt", 7'h4B, 8'h00);
        rd("rst_pend", 7'h40, 8'h00);
        rd("rst_tctl", 7'h4A, 8'h00);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_out", out_ports, 32'h0);
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
